seq_input_conditioner: RTL and testbench



---
 rtl/seq_pkg.sv | 15 +
 rtl/bit_synchronizer.sv | 23 ++
 rtl/seq_input_conditioner.sv | 116 +++++++++++
 tb/tb_seq_input_conditioner.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the input conditioner: debounce FSM encodings and
// default synchroniser / debounce depths.
package seq_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        PEND_HIGH   = 2'b01,
        STABLE_HIGH = 2'b11,
        PEND_LOW    = 2'b10
    } state_t;

    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous bit. The input feeds the
// first flop directly so no combinational logic sits ahead of the chain.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/seq_input_conditioner.sv
// Synchronises and debounces a raw pad bit into a clean level for the "1111"
// detector, with registered edge pulses and a saturating glitch counter.
module seq_input_conditioner
    import seq_pkg::*;
#(
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 5,
    parameter int GLITCH_W        = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                raw_in,
    input  logic                glitch_clr,
    output logic                level_out,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [GLITCH_W-1:0] glitch_count
);

    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    logic                s;
    logic                accept;
    logic                glitch_event;
    logic                level_next;
    logic                rise_next;
    logic                fall_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [GLITCH_W-1:0] glitch_next;
    state_t              state;
    state_t              next_state;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (raw_in),
        .q     (s)
    );

    // With DEBOUNCE_CYCLES=1 the first pending cycle already matches.
    assign accept = (cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= STABLE_LOW;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned,
        // which would otherwise infer a latch.
        next_state = state;
        case (state)
            STABLE_LOW:  if (s) next_state = PEND_HIGH;
            PEND_HIGH:   if (!s) next_state = STABLE_LOW;
                         else if (accept) next_state = STABLE_HIGH;
            STABLE_HIGH: if (!s) next_state = PEND_LOW;
            PEND_LOW:    if (s) next_state = STABLE_HIGH;
                         else if (accept) next_state = STABLE_LOW;
            default:     next_state = STABLE_LOW;
        endcase
    end

    always_comb begin
        cnt_next     = cnt;
        level_next   = level_out;
        rise_next    = 1'b0;
        fall_next    = 1'b0;
        glitch_event = 1'b0;
        case (state)
            STABLE_LOW:  if (s) cnt_next = '0;
            PEND_HIGH: begin
                if (!s) glitch_event = 1'b1;
                else if (accept) begin
                    level_next = 1'b1;
                    rise_next  = 1'b1;
                end else cnt_next = cnt + CNT_W'(1);
            end
            STABLE_HIGH: if (!s) cnt_next = '0;
            PEND_LOW: begin
                if (s) glitch_event = 1'b1;
                else if (accept) begin
                    level_next = 1'b0;
                    fall_next  = 1'b1;
                end else cnt_next = cnt + CNT_W'(1);
            end
            default: cnt_next = '0;
        endcase

        // Clear outranks a coincident glitch; the count sticks at all-ones.
        if (glitch_clr)                                     glitch_next = '0;
        else if (glitch_event && glitch_count != GLITCH_MAX) glitch_next = glitch_count + GLITCH_W'(1);
        else                                                glitch_next = glitch_count;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt          <= '0;
            level_out    <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            glitch_count <= '0;
        end else begin
            cnt          <= cnt_next;
            level_out    <= level_next;
            rise_pulse   <= rise_next;
            fall_pulse   <= fall_next;
            glitch_count <= glitch_next;
        end
    end

endmodule

// File: tb/tb_seq_input_conditioner.sv
// Bench for seq_input_conditioner: a default instance and a shallow-debounce,
// 2-bit-counter instance share stimulus and are checked against a run-length model.
module tb_seq_input_conditioner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       raw_in = 1'b0;
    logic       glitch_clr = 1'b0;
    logic       a_level, a_rise, a_fall;
    logic [7:0] a_glitch;
    logic       b_level, b_rise, b_fall;
    logic [1:0] b_glitch;

    always #5 clock = ~clock;

    seq_input_conditioner u_a (
        .clock        (clock),
        .reset        (reset),
        .raw_in       (raw_in),
        .glitch_clr   (glitch_clr),
        .level_out    (a_level),
        .rise_pulse   (a_rise),
        .fall_pulse   (a_fall),
        .glitch_count (a_glitch)
    );

    seq_input_conditioner #(
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (1),
        .CNT_W           (1),
        .GLITCH_W        (2)
    ) u_b (
        .clock        (clock),
        .reset        (reset),
        .raw_in       (raw_in),
        .glitch_clr   (glitch_clr),
        .level_out    (b_level),
        .rise_pulse   (b_rise),
        .fall_pulse   (b_fall),
        .glitch_count (b_glitch)
    );

    // Moore "1111" detector standing in for the downstream block.
    int   det_ones;
    logic det_out;
    always @(posedge clock or posedge reset) begin
        if (reset)        det_ones <= 0;
        else if (a_level) det_ones <= (det_ones < 4) ? det_ones + 1 : 4;
        else              det_ones <= 0;
    end
    assign det_out = (det_ones == 4);

    // Reference model: a new level is accepted once the synchronised input has
    // disagreed with it for DEBOUNCE+1 consecutive edges; a shorter run is a glitch.
    int m_sync[2] = '{2, 3};
    int m_deb[2]  = '{16, 1};
    int m_max[2]  = '{255, 3};
    int m_run[2];
    int m_glitch[2];
    bit m_level[2];
    bit m_rise[2];
    bit m_fall[2];
    bit hist[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int a_rise_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_glitch[i] = 0; m_level[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
        end
        hist.delete();
    endtask

    task automatic model_edge(input bit raw, input bit clr);
        for (int i = 0; i < 2; i++) begin
            bit s;
            s = (hist.size() >= m_sync[i]) ? hist[hist.size() - m_sync[i]] : 1'b0;
            m_rise[i] = 0;
            m_fall[i] = 0;
            if (s != m_level[i]) begin
                m_run[i]++;
                if (m_run[i] == m_deb[i] + 1) begin
                    m_level[i] = s;
                    if (s) m_rise[i] = 1; else m_fall[i] = 1;
                    m_run[i] = 0;
                end
            end else begin
                if (m_run[i] > 0 && m_glitch[i] < m_max[i]) m_glitch[i]++;
                m_run[i] = 0;
            end
            if (clr) m_glitch[i] = 0;
        end
        hist.push_back(raw);
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic step(input bit raw, input bit clr);
        raw_in     = raw;
        glitch_clr = clr;
        @(posedge clock);
        model_edge(raw, clr);
        cyc++;
        #1;
        if (a_rise) a_rise_cnt++;
        check("a_level",  a_level,  m_level[0]);
        check("a_rise",   a_rise,   m_rise[0]);
        check("a_fall",   a_fall,   m_fall[0]);
        check("a_glitch", a_glitch, m_glitch[0]);
        check("b_level",  b_level,  m_level[1]);
        check("b_rise",   b_rise,   m_rise[1]);
        check("b_fall",   b_fall,   m_fall[1]);
        check("b_glitch", b_glitch, m_glitch[1]);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_a_level"},  a_level,  0);
        check({name, "_a_rise"},   a_rise,   0);
        check({name, "_a_fall"},   a_fall,   0);
        check({name, "_a_glitch"}, a_glitch, 0);
        check({name, "_b_level"},  b_level,  0);
        check({name, "_b_glitch"}, b_glitch, 0);
    endtask

    task automatic do_reset();
        raw_in     = 1'b0;
        glitch_clr = 1'b0;
        reset      = 1'b1;
        #1;
        check_all_zero("reset");
        model_reset();
        @(posedge clock);
        #1;
        reset      = 1'b0;
        cyc        = 0;
        a_rise_cnt = 0;
    endtask

    typedef struct {
        bit raw;
        bit clr;
        int reps;
        bit exp_level;
        bit exp_rise;
        bit exp_fall;
        int exp_glitch;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int lvl_rise, lvl_fall, det_rise, det_fall;

        vecs[0] = '{1, 0, 18, 0, 0, 0, 0};  // edge 18: not yet accepted
        vecs[1] = '{1, 0, 1,  1, 1, 0, 0};  // edge 19: accepted
        vecs[2] = '{1, 0, 1,  1, 0, 0, 0};  // pulse lasts one cycle
        vecs[3] = '{0, 0, 5,  1, 0, 0, 0};
        vecs[4] = '{1, 0, 5,  1, 0, 0, 1};  // low glitch rejected
        vecs[5] = '{0, 0, 19, 0, 0, 1, 1};  // full debounce low
        vecs[6] = '{0, 0, 1,  0, 0, 0, 1};
        vecs[7] = '{1, 0, 5,  0, 0, 0, 1};
        vecs[8] = '{0, 0, 5,  0, 0, 0, 2};  // high glitch rejected
        vecs[9] = '{0, 1, 1,  0, 0, 0, 0};  // clear

        // Table-driven: clean rise, glitches both ways, clean fall, clear.
        do_reset();
        for (int v = 0; v < 10; v++) begin
            for (int r = 0; r < vecs[v].reps; r++) step(vecs[v].raw, vecs[v].clr);
            check($sformatf("vec%0d_level", v),  a_level,  vecs[v].exp_level);
            check($sformatf("vec%0d_rise", v),   a_rise,   vecs[v].exp_rise);
            check($sformatf("vec%0d_fall", v),   a_fall,   vecs[v].exp_fall);
            check($sformatf("vec%0d_glitch", v), a_glitch, vecs[v].exp_glitch);
        end

        // Single-cycle debounce: level changes at edge SYNC+1+1 = 5.
        do_reset();
        for (int r = 0; r < 4; r++) step(1, 0);
        check("deb1_level_e4", b_level, 0);
        step(1, 0);
        check("deb1_level_e5", b_level, 1);
        check("deb1_rise_e5",  b_rise,  1);

        // Bounce train then settle.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < 4; r++) step(1, 0);
            for (int r = 0; r < 4; r++) step(0, 0);
        end
        for (int r = 0; r < 25; r++) step(1, 0);
        check("bounce_glitch", a_glitch,   3);
        check("bounce_rises",  a_rise_cnt, 1);
        check("bounce_level",  a_level,    1);

        // Saturation of the 2-bit counter, then clear coinciding with a glitch.
        do_reset();
        for (int p = 0; p < 5; p++) begin
            step(1, 0);
            for (int r = 0; r < 4; r++) step(0, 0);
        end
        check("sat_b_glitch", b_glitch, 3);
        check("sat_a_glitch", a_glitch, 5);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 0);
        check("sat_b_before_clr", b_glitch, 3);
        step(0, 1);
        check("clr_wins_b", b_glitch, 0);
        check("clr_wins_a", a_glitch, 0);

        // Reset mid-debounce, then a full debounce after release.
        do_reset();
        for (int r = 0; r < 10; r++) step(1, 0);
        reset = 1'b1;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(posedge clock);
        #1;
        reset      = 1'b0;
        cyc        = 0;
        a_rise_cnt = 0;
        for (int r = 0; r < 18; r++) step(1, 0);
        check("midrst_level_e18", a_level, 0);
        step(1, 0);
        check("midrst_level_e19", a_level, 1);
        for (int r = 0; r < 6; r++) step(1, 0);
        check("midrst_rises", a_rise_cnt, 1);

        // Integration with the downstream "1111" detector.
        do_reset();
        lvl_rise = -1; lvl_fall = -1; det_rise = -1; det_fall = -1;
        for (int r = 0; r < 60; r++) begin
            step(r < 30, 0);
            if (a_level && lvl_rise < 0)                  lvl_rise = cyc;
            if (!a_level && lvl_rise >= 0 && lvl_fall < 0) lvl_fall = cyc;
            if (det_out && det_rise < 0)                  det_rise = cyc;
            if (!det_out && det_rise >= 0 && det_fall < 0) det_fall = cyc;
        end
        check("int_level_rise", lvl_rise, 19);
        check("int_det_rise",   det_rise, 23);
        check("int_level_fall", lvl_fall, 49);
        check("int_det_fall",   det_fall, 50);

        // Randomised runs with occasional clears.
        do_reset();
        for (int k = 0; k < 120; k++) begin
            bit val;
            int len;
            val = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 22);
            for (int r = 0; r < len; r++) step(val, $urandom_range(0, 40) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
